// File: rtl/ddr3_ring_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ring_bridge_if
// Purpose  : Bundles the input FIFO, output FIFO and MIG user-interface
//            signals of the DDR3 ring bridge into one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr3_ring_bridge_if;
    // input FIFO (first-word-not-fall-through, 1-cycle read latency)
    logic         ib_re;
    logic [255:0] ib_data;
    logic [6:0]   ib_count;
    logic         ib_valid;
    logic         ib_empty;
    // output FIFO
    logic         ob_we;
    logic [255:0] ob_data;
    logic [6:0]   ob_count;
    logic         ob_full;
    // MIG command channel
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [29:0]  app_addr;
    logic         app_rdy;
    // MIG write-data channel
    logic         app_wdf_wren;
    logic [255:0] app_wdf_data;
    logic         app_wdf_end;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    // MIG read-data channel
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;

    // bridge side
    modport master (
        output ib_re, ob_we, ob_data,
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
        input  ib_data, ib_count, ib_valid, ib_empty,
        input  ob_count, ob_full,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    // FIFO / memory-controller side
    modport slave (
        input  ib_re, ob_we, ob_data,
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
        output ib_data, ib_count, ib_valid, ib_empty,
        output ob_count, ob_full,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface
`default_nettype wire

// File: rtl/ddr3_ring_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ring_bridge
// Purpose  : Uses a DDR3 region as a ring buffer between an input FIFO and an
//            output FIFO. Words are written in bursts of BURST_LEN through the
//            MIG user interface and read back in the same order.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_ring_bridge #(
    parameter int BURST_LEN  = 8,
    parameter int RING_WORDS = 16777216,
    parameter int OB_LIMIT   = 100
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           calib_done,
    input  wire logic           writes_en,
    input  wire logic           reads_en,
    output logic [24:0]         level,
    ddr3_ring_bridge_if.master  bus
);

    localparam int PTR_W = (RING_WORDS > 1) ? $clog2(RING_WORDS) : 1;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam int OUT_W = 16;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RING_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_FETCH = 2'd1,
        WR_ISSUE = 2'd2,
        RD_ISSUE = 2'd3
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  word_cnt;
    logic [OUT_W-1:0]  outstanding;
    logic              last_read;

    logic              wr_elig;
    logic              rd_elig;
    logic              grant_wr;
    logic              grant_rd;
    logic              wr_done;
    logic              rd_acc;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;

    // Word index to MIG byte-ish address: 8 columns per 256-bit word.
    function automatic logic [29:0] addr_of(input logic [PTR_W-1:0] p);
        logic [29:0] a;
        a = 30'(p);
        return a << 3;
    endfunction

    // Pointers wrap explicitly at the top of the ring.
    assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

    // Burst eligibility; outstanding reads reserve room in the output FIFO.
    assign wr_elig = calib_done && writes_en
                  && (32'(bus.ib_count) >= 32'(BURST_LEN))
                  && ((32'(level) + 32'(BURST_LEN)) <= 32'(RING_WORDS));
    assign rd_elig = calib_done && reads_en
                  && (32'(level) >= 32'(BURST_LEN))
                  && ((32'(bus.ob_count) + 32'(outstanding) + 32'(BURST_LEN))
                      <= 32'(OB_LIMIT));

    // Alternate between writes and reads when both want the memory.
    assign grant_wr = wr_elig && (!rd_elig || last_read);
    assign grant_rd = rd_elig && !grant_wr;

    // A write word completes once both its data and its command are taken.
    assign wr_done = (state == WR_ISSUE)
                  && (!bus.app_wdf_wren || bus.app_wdf_rdy)
                  && (!bus.app_en || bus.app_rdy);
    assign rd_acc  = (state == RD_ISSUE) && bus.app_en && bus.app_rdy;

    assign bus.app_wdf_mask = '0;

    // Status inputs that the bridge deliberately does not act on.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ib_empty, bus.ob_full, bus.app_rd_data_end};

    // Main sequencer: burst arbitration, fetch and MIG handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.ib_re        <= 1'b0;
            bus.app_en       <= 1'b0;
            bus.app_cmd      <= 3'b000;
            bus.app_addr     <= '0;
            bus.app_wdf_wren <= 1'b0;
            bus.app_wdf_end  <= 1'b0;
            bus.app_wdf_data <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            word_cnt         <= '0;
            last_read        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus.ib_re        <= 1'b0;
                    bus.app_en       <= 1'b0;
                    bus.app_wdf_wren <= 1'b0;
                    bus.app_wdf_end  <= 1'b0;
                    word_cnt         <= '0;
                    if (grant_wr) begin
                        state     <= WR_FETCH;
                        bus.ib_re <= 1'b1;
                        last_read <= 1'b0;
                    end else if (grant_rd) begin
                        state        <= RD_ISSUE;
                        bus.app_en   <= 1'b1;
                        bus.app_cmd  <= 3'b001;
                        bus.app_addr <= addr_of(rd_ptr);
                        last_read    <= 1'b1;
                    end
                end
                WR_FETCH: begin
                    bus.ib_re <= 1'b0;
                    // data arrives the cycle after the single ib_re pulse
                    if (!bus.ib_re && bus.ib_valid) begin
                        bus.app_wdf_data <= bus.ib_data;
                        bus.app_wdf_wren <= 1'b1;
                        bus.app_wdf_end  <= 1'b1;
                        bus.app_en       <= 1'b1;
                        bus.app_cmd      <= 3'b000;
                        bus.app_addr     <= addr_of(wr_ptr);
                        state            <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
                        bus.app_wdf_wren <= 1'b0;
                        bus.app_wdf_end  <= 1'b0;
                    end
                    if (bus.app_en && bus.app_rdy) begin
                        bus.app_en <= 1'b0;
                    end
                    if (wr_done) begin
                        wr_ptr <= wr_ptr_nxt;
                        if (word_cnt == CNT_LAST) begin
                            word_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            word_cnt  <= word_cnt + 1'b1;
                            bus.ib_re <= 1'b1;
                            state     <= WR_FETCH;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bus.app_rdy) begin
                        rd_ptr <= rd_ptr_nxt;
                        if (word_cnt == CNT_LAST) begin
                            word_cnt   <= '0;
                            bus.app_en <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            word_cnt     <= word_cnt + 1'b1;
                            bus.app_addr <= addr_of(rd_ptr_nxt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ring occupancy: a write completion and a read acceptance cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({wr_done, rd_acc})
                2'b10:   level <= level + 25'd1;
                2'b01:   level <= level - 25'd1;
                default: level <= level;
            endcase
        end
    end

    // Read commands in flight whose data has not yet returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            if (rd_acc && !bus.app_rd_data_valid) begin
                outstanding <= outstanding + 1'b1;
            end else if (!rd_acc && bus.app_rd_data_valid && (outstanding != '0)) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    // Returned read data goes straight to the output FIFO, one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ob_we   <= 1'b0;
            bus.ob_data <= '0;
        end else begin
            bus.ob_we   <= bus.app_rd_data_valid;
            bus.ob_data <= bus.app_rd_data;
        end
    end

endmodule
`default_nettype wire
